// File: rtl/mult_mem_pkg.sv
// Shared definitions for the matmul result path.
// Holds the result/Avalon widths and the result-writer state type.
package mult_mem_pkg;

  localparam int RESULT_WIDTH      = 24;
  localparam int AVALON_DATA_WIDTH = 32;
  localparam int AVALON_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_t;

  // Zero-extend a result element onto the Avalon data bus.
  function automatic logic [AVALON_DATA_WIDTH-1:0] widen_result(
    input logic [RESULT_WIDTH-1:0] value
  );
    return {{(AVALON_DATA_WIDTH-RESULT_WIDTH){1'b0}}, value};
  endfunction

endpackage

// File: rtl/avalon_result_writer.sv
// avalon_result_writer
// Captures a matmul result vector (and optionally its sum) on a start pulse
// and writes it out word by word as an Avalon-MM master.
//
// Configuration macro: WRITE_SUM_EN -- when defined, the sum is written as an
// extra word after the vector (N = DEPTH+1); otherwise N = DEPTH and the sum
// port is ignored.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          single-cycle "results valid" pulse (accepted only when idle)
//   c_vector       DEPTH result elements, RESULT_WIDTH bits each
//   sum            result sum (used only with WRITE_SUM_EN)
//   address        Avalon byte address, BASE_ADDR + 4*index
//   write          Avalon write request
//   writedata      zero-extended result word
//   byteenable     constant all-ones
//   waitrequest    Avalon slave stall
//   busy           high from accepted start until done
//   done           one-cycle pulse after the last write is accepted
module avalon_result_writer
  import mult_mem_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [RESULT_WIDTH-1:0]      c_vector [0:DEPTH-1],
  input  logic [RESULT_WIDTH-1:0]      sum,
  output logic [AVALON_ADDR_WIDTH-1:0] address,
  output logic                         write,
  output logic [AVALON_DATA_WIDTH-1:0] writedata,
  output logic [3:0]                   byteenable,
  input  logic                         waitrequest,
  output logic                         busy,
  output logic                         done
);

`ifdef WRITE_SUM_EN
  localparam int N_WORDS = DEPTH + 1;
`else
  localparam int N_WORDS = DEPTH;
`endif

  localparam int IDX_W = $clog2(DEPTH + 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  wr_state_t               state, state_next;
  logic [IDX_W-1:0]        idx, idx_next;
  logic [RESULT_WIDTH-1:0] c_reg [0:DEPTH-1];
  logic                    capture;
  logic                    accept;
  logic [RESULT_WIDTH-1:0] elem;

`ifdef WRITE_SUM_EN
  logic [RESULT_WIDTH-1:0] sum_reg;
`else
  logic sum_unused;
  assign sum_unused = ^sum;
`endif

  // State, index and capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        c_reg[i] <= '0;
      end
`ifdef WRITE_SUM_EN
      sum_reg <= '0;
`endif
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (capture) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          c_reg[i] <= c_vector[i];
        end
`ifdef WRITE_SUM_EN
        sum_reg <= sum;
`endif
      end
    end
  end

  assign accept = (state == ST_WRITE) && !waitrequest;

  // Next-state, index and capture control.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    capture    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          capture    = 1'b1;
          idx_next   = '0;
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (accept) begin
          if (idx == LAST_IDX) begin
            state_next = ST_DONE;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Word select: vector elements first, then the sum (if enabled) at index DEPTH.
  always_comb begin
`ifdef WRITE_SUM_EN
    elem = sum_reg;
`else
    elem = '0;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (idx == IDX_W'(i)) begin
        elem = c_reg[i];
      end
    end
  end

  // Outputs decode from registered state only, so they hold stable under
  // waitrequest and drop to zero as soon as reset asserts.
  always_comb begin
    write      = 1'b0;
    address    = '0;
    writedata  = '0;
    byteenable = 4'hF;
    busy       = (state != ST_IDLE);
    done       = (state == ST_DONE);
    if (state == ST_WRITE) begin
      write     = 1'b1;
      address   = BASE_ADDR + (AVALON_ADDR_WIDTH'(idx) << 2);
      writedata = widen_result(elem);
    end
  end

endmodule

// File: tb/tb_avalon_result_writer.sv
module tb_avalon_result_writer;

  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef WRITE_SUM_EN
  localparam int N          = DEPTH + 1;
  localparam int DONE_CYC_0 = 10;
`else
  localparam int N          = DEPTH;
  localparam int DONE_CYC_0 = 9;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] c_vector [0:DEPTH-1];
  logic [23:0] sum;
  logic [31:0] address;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic        busy;
  logic        done;

  avalon_result_writer #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .c_vector(c_vector), .sum(sum),
    .address(address), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending (address,data) words loaded on an
  // accepted start, popped on each accepted write, plus a one-cycle done flag.
  logic [31:0] m_addr [$];
  logic [31:0] m_data [$];
  bit          m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_addr.delete();
      m_data.delete();
      m_done = 1'b0;
    end else if (m_addr.size() > 0) begin
      if (!waitrequest) begin
        void'(m_addr.pop_front());
        void'(m_data.pop_front());
        if (m_addr.size() == 0) m_done = 1'b1;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (start) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_addr.push_back(BASE + 32'(4 * i));
        m_data.push_back({8'h00, c_vector[i]});
      end
`ifdef WRITE_SUM_EN
      m_addr.push_back(BASE + 32'(4 * DEPTH));
      m_data.push_back({8'h00, sum});
`endif
    end
  end

  // Logs of accepted writes and observed events, for per-test literal checks.
  logic [31:0] acc_addr [$];
  logic [31:0] acc_data [$];
  int          done_cnt = 0;
  int          hold8_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_write", {31'b0, write}, 32'h0);
      check("rst_done", {31'b0, done}, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_address", address, 32'h0);
      check("rst_writedata", writedata, 32'h0);
    end else begin
      check("write", {31'b0, write}, {31'b0, m_addr.size() > 0});
      check("done", {31'b0, done}, {31'b0, m_done});
      check("busy", {31'b0, busy}, {31'b0, (m_addr.size() > 0) || m_done});
      check("byteenable", {28'b0, byteenable}, 32'hF);
      if (m_addr.size() > 0) begin
        check("address", address, m_addr[0]);
        check("writedata", writedata, m_data[0]);
      end
      if (write && !waitrequest) begin
        acc_addr.push_back(address);
        acc_data.push_back(writedata);
      end
      if (done) done_cnt++;
      if (write && address == 32'h8) hold8_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    acc_addr.delete();
    acc_data.delete();
    done_cnt  = 0;
    hold8_cnt = 0;
  endtask

  task automatic load_counting(input logic [23:0] first);
    for (int i = 0; i < DEPTH; i++) c_vector[i] = (i == 0) ? first : 24'(i + 1);
    sum = 24'd36;
  endtask

  // Pulses start, then runs until done (or budget). cnt counts edges after the
  // start edge; done visible after edge k means done at cycle k+1.
  task automatic run_xfer(input int stall_at, input int stall_len,
                          input int restart_at, input int reset_at,
                          output int done_cyc);
    int cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    cnt = 0;
    done_cyc = -1;
    while (cnt < 100) begin
      if (cnt == reset_at) begin
        rst_n = 1'b0;
        #1;
        check("async_rst_write", {31'b0, write}, 32'h0);
        check("async_rst_busy", {31'b0, busy}, 32'h0);
        check("async_rst_addr", address, 32'h0);
        return;
      end
      if (done) begin
        done_cyc = cnt + 1;
        break;
      end
      waitrequest = (stall_at >= 0 && cnt >= stall_at && cnt < stall_at + stall_len);
      if (cnt == restart_at) begin
        start = 1'b1;
        for (int i = 0; i < DEPTH; i++) c_vector[i] = 24'hA00 + 24'(i);
        sum = 24'h555;
      end else begin
        start = 1'b0;
      end
      step();
      cnt++;
    end
    start = 1'b0;
    waitrequest = 1'b0;
    if (done_cyc < 0) check("done_timeout", 32'hFFFF_FFFF, 32'(N + 1));
    step();
    step();
  endtask

  task automatic check_sequence(input string name, input logic [23:0] first);
    logic [31:0] exp_d;
    check({name, "_nwrites"}, 32'(acc_addr.size()), 32'(N));
    for (int i = 0; i < N && i < acc_addr.size(); i++) begin
      exp_d = (i == DEPTH) ? 32'h24 : ((i == 0) ? {8'h00, first} : 32'(i + 1));
      check({name, "_addr"}, acc_addr[i], 32'(4 * i));
      check({name, "_data"}, acc_data[i], exp_d);
    end
    check({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
  endtask

  int dcyc;
  int n08;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    waitrequest = 1'b0;
    sum = '0;
    for (int i = 0; i < DEPTH; i++) c_vector[i] = '0;
    #1;
    check("reset_write", {31'b0, write}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_addr", address, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Test 1: nominal transfer.
    clear_logs();
    load_counting(24'd1);
    run_xfer(-1, 0, -1, -1, dcyc);
    check("t1_done_cycle", 32'(dcyc), 32'(DONE_CYC_0));
    check_sequence("t1", 24'd1);
    check("t1_no_0x20", 32'(acc_addr.size() > DEPTH && acc_addr[DEPTH] == 32'h20),
`ifdef WRITE_SUM_EN
          32'd1);
`else
          32'd0);
`endif

    // Test 2: three-cycle stall on word 2.
    clear_logs();
    load_counting(24'd1);
    run_xfer(2, 3, -1, -1, dcyc);
    check("t2_done_cycle", 32'(dcyc), 32'(DONE_CYC_0 + 3));
    check("t2_hold_cycles", 32'(hold8_cnt), 32'd4);
    n08 = 0;
    foreach (acc_addr[i]) if (acc_addr[i] == 32'h8) n08++;
    check("t2_accepts_0x08", 32'(n08), 32'd1);
    check_sequence("t2", 24'd1);

    // Test 3: full-scale element is zero-extended.
    clear_logs();
    load_counting(24'hFFFFFF);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t3_writedata", writedata, 32'h00FF_FFFF);
    check("t3_byteenable", {28'b0, byteenable}, 32'hF);
    repeat (N + 3) step();
    check_sequence("t3", 24'hFFFFFF);

    // Test 4: start during WRITE with different data is ignored.
    clear_logs();
    load_counting(24'd1);
    run_xfer(-1, 0, 3, -1, dcyc);
    check_sequence("t4", 24'd1);
    repeat (3) step();
    check("t4_no_second", 32'(acc_addr.size()), 32'(N));

    // Test 5: reset asserted while word 4 is presented.
    clear_logs();
    load_counting(24'd1);
    run_xfer(-1, 0, -1, 4, dcyc);
    repeat (3) step();
    check("t5_writes_before_rst", 32'(acc_addr.size()), 32'd4);
    check("t5_no_done", 32'(done_cnt), 32'd0);
    rst_n = 1'b1;
    step();
    clear_logs();
    load_counting(24'd1);
    run_xfer(-1, 0, -1, -1, dcyc);
    check_sequence("t5_fresh", 24'd1);

    // Start in the DONE cycle is ignored, start right after is accepted.
    clear_logs();
    load_counting(24'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (N) step();
    check("done_cycle_pulse", {31'b0, done}, 32'h1);
    start = 1'b1;
    step();
    check("start_in_done_ignored", {31'b0, busy}, 32'h0);
    step();
    start = 1'b0;
    check("start_after_done", {31'b0, busy}, 32'h1);
    repeat (N + 3) step();
    check("back_to_back_done", 32'(done_cnt), 32'd2);

    // Randomised traffic against the model.
    for (int c = 0; c < 600; c++) begin
      waitrequest = ($urandom_range(0, 9) < 3);
      start = ($urandom_range(0, 9) < 2);
      for (int i = 0; i < DEPTH; i++) c_vector[i] = 24'($urandom());
      sum = 24'($urandom());
      if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      step();
    end
    rst_n = 1'b1;
    start = 1'b0;
    waitrequest = 1'b0;
    repeat (N + 4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/avalon_result_writer.md
AVALON_RESULT_WRITER -- requirements
Module: avalon_result_writer

Interface
REQ-001 Parameter DEPTH, default 8: number of result elements written per transfer.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first result word.
REQ-003 Port clk  input  1  single clock; all logic on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port start  input  1  results valid; single-cycle pulse from the matmul stage.
REQ-006 Port c_vector  input  24 x [0:DEPTH-1]  result vector, sampled on accepted start.
REQ-007 Port sum  input  24  result sum, sampled on accepted start.
REQ-008 Port address  output  32  Avalon-MM byte address.
REQ-009 Port write  output  1  Avalon-MM write request.
REQ-010 Port writedata  output  32  Avalon-MM write data.
REQ-011 Port byteenable  output  4  Avalon-MM byte enables; constant 4'hF.
REQ-012 Port waitrequest  input  1  Avalon-MM stall from slave.
REQ-013 Port busy  output  1  high from accepted start until done.
REQ-014 Port done  output  1  one-cycle pulse after the last write is accepted.

Function
REQ-015 The FSM SHALL have states IDLE, WRITE, DONE.
REQ-016 In IDLE, start=1 SHALL capture c_vector and sum into internal registers, clear the word index, and move to WRITE next cycle.
REQ-017 start SHALL be ignored in WRITE and DONE; captured data SHALL NOT change.
REQ-018 In WRITE, write SHALL be 1, address SHALL be BASE_ADDR + 4*index, and writedata SHALL be {8'h00, element} (zero-extended).
REQ-019 Word index i < DEPTH SHALL select c_vector[i]; index DEPTH (only when sum is written) SHALL select sum.
REQ-020 A write SHALL be accepted on a rising edge with write=1 and waitrequest=0; the index SHALL then increment.
REQ-021 While waitrequest=1, address, writedata and write SHALL hold stable.
REQ-022 After the final word is accepted, the FSM SHALL enter DONE for exactly one cycle with done=1 and write=0, then return to IDLE.
REQ-023 Latency with waitrequest held low: start at cycle 0, word i accepted at cycle 1+i, done at cycle 1+N, where N is the word count.
REQ-024 busy SHALL be 1 in WRITE and DONE and 0 in IDLE.
REQ-025 start asserted in the DONE cycle SHALL be ignored; start in the cycle after DONE SHALL be accepted.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, write=0, done=0, busy=0, address=0, writedata=0, index=0, and captured registers=0.
REQ-027 Reset mid-transfer SHALL abandon the transfer, emit no done pulse, and perform no further writes.

Configuration
REQ-028 With WRITE_SUM_EN defined, N SHALL be DEPTH+1, with sum written at BASE_ADDR + 4*DEPTH.
REQ-029 Without WRITE_SUM_EN, N SHALL be DEPTH, the sum register SHALL be omitted, and the sum port SHALL be ignored.

Structure
REQ-030 Shared package mult_mem_pkg SHALL hold RESULT_WIDTH=24, AVALON_DATA_WIDTH=32, AVALON_ADDR_WIDTH=32 and the state enum typedef.
REQ-031 No sub-module SHALL be used; the FSM, index counter and capture registers SHALL live in one module.

Verification
REQ-032 Test 1: WRITE_SUM_EN defined, DEPTH=8, c_vector[i]=i+1, sum=36, waitrequest=0, one start pulse.
- Required: 9 writes to 0x00..0x20 with data 1..8 then 36.
- Required: done at cycle 10.
REQ-033 Test 2: waitrequest held high for 3 cycles on word 2.
- Required: address 0x08 and data held stable for all 4 cycles.
- Required: exactly one write accepted at 0x08.
- Required: done delayed 3 cycles relative to Test 1.
REQ-034 Test 3: c_vector[0]=24'hFFFFFF.
- Required: writedata=32'h00FFFFFF and byteenable=4'hF.
REQ-035 Test 4: start pulsed again during WRITE with different data.
- Required: the original values are written.
- Required: exactly N writes and one done pulse.
REQ-036 Test 5: rst_n low at word 4.
- Required: write=0 asynchronously.
- Required: no done pulse.
- Required: a fresh start after reset writes all words from BASE_ADDR.
REQ-037 Test 6: WRITE_SUM_EN undefined, DEPTH=8.
- Required: exactly 8 writes.
- Required: no write to 0x20.
- Required: done at cycle 9.
